// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver and its Wishbone register file.
package ps2_kbd_pkg;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;
    localparam logic [1:0] ADR_RSVD   = 2'd3;

    localparam int ST_EMPTY      = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERRUN    = 2;
    localparam int ST_PARITY_ERR = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_COUNT_LSB  = 8;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

    // Odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronise and filter both lines, then decode 11-bit frames on clock falls.
//   state  | meaning
//   IDLE   | waiting for a start bit (data 0 on a fall)
//   DATA   | shifting in eight data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking stop bit and parity, then reporting the byte or an error
module ps2_frame_rx
    import ps2_kbd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 20,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_TC = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_LOAD = TCW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic [1:0]             smp, filt;
    logic [FCW-1:0]         flt_cnt [2];
    logic                   clk_filt_q, fall;

    frame_state_t   state, state_nxt;
    logic [7:0]     shreg;
    logic [2:0]     bit_idx;
    logic           par_bit;
    logic [TCW-1:0] tmo_cnt;
    logic           tmo_hit;

    // Index 0 is the clock line, index 1 the data line.
    assign smp  = {dat_sync[SYNC_STAGES-1], clk_sync[SYNC_STAGES-1]};
    assign fall = clk_filt_q & ~filt[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync   <= '1;
            dat_sync   <= '1;
            filt       <= 2'b11;
            clk_filt_q <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2clk_i};
            dat_sync   <= {dat_sync[SYNC_STAGES-2:0], ps2data_i};
            clk_filt_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (smp[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FILT_TC) begin
                    filt[i]    <= smp[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FCW'(1);
                end
            end
        end
    end

    assign tmo_hit = (state != IDLE) && (tmo_cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= TMO_LOAD;
        end else begin
            state <= state_nxt;
            if (state == IDLE || fall) tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)    tmo_cnt <= tmo_cnt - TCW'(1);
            if (fall) begin
                case (state)
                    IDLE:    bit_idx <= '0;
                    DATA: begin
                        shreg   <= {filt[1], shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                    PARITY:  par_bit <= filt[1];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_valid = 1'b0;
        parity_err = 1'b0;
        frame_err  = 1'b0;
        if (tmo_hit) begin
            frame_err = 1'b1;
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:   if (!filt[1]) state_nxt = DATA;
                DATA:   if (bit_idx == 3'd7) state_nxt = PARITY;
                PARITY: state_nxt = STOP;
                STOP: begin
                    if (filt[1] && odd_parity_ok(shreg, par_bit)) begin
                        byte_valid = 1'b1;
                    end else begin
                        parity_err = ~odd_parity_ok(shreg, par_bit);
                        frame_err  = ~filt[1];
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/ps2_keyboard_fifo_wb.sv
// PS/2 keyboard receiver with a scan-code FIFO, status/control registers and a Wishbone slave port.
module ps2_keyboard_fifo_wb
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 20,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    input  logic        ps2clk_i,
    input  logic        ps2data_i,
    output logic        irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    rx_byte;
    logic          byte_valid, parity_pulse, frame_pulse;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, do_push, pop, flush;
    logic          overrun, parity_err, frame_err, irq_en;

    logic          req, wr, rd;
    logic [1:0]    req_adr;
    logic          req_we, req_sel0;
    logic [4:0]    req_wdat;
    logic [2:0]    sts_clr;
    logic [31:0]   status, rdata;
    logic          unused_bits;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ps2clk_i  (ps2clk_i),
        .ps2data_i (ps2data_i),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .parity_err(parity_pulse),
        .frame_err (frame_pulse)
    );

    assign unused_bits = ^{wb_dat_i[31:5], wb_sel_i[3:1]};

    // The request is captured so the ack cycle acts on it regardless of when the master drops stb.
    assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr  = wb_ack_o & req_we & req_sel0;
    assign rd  = wb_ack_o & ~req_we;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            req_adr  <= '0;
            req_we   <= 1'b0;
            req_sel0 <= 1'b0;
            req_wdat <= '0;
        end else begin
            wb_ack_o <= req;
            if (req) begin
                req_adr  <= wb_adr_i;
                req_we   <= wb_we_i;
                req_sel0 <= wb_sel_i[0];
                req_wdat <= wb_dat_i[4:0];
            end
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = rd & (req_adr == ADR_DATA) & ~empty;
    assign flush   = wr & (req_adr == ADR_CTRL) & req_wdat[CTRL_FLUSH];
    assign do_push = byte_valid & (~full | pop) & ~flush;
    assign sts_clr = (wr && req_adr == ADR_STATUS) ? req_wdat[4:2] : 3'b000;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            irq_en     <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)     rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(do_push) - CW'(pop);
            end
            // Set has priority over a same-cycle W1C clear.
            overrun    <= (byte_valid & full & ~pop & ~flush) | (overrun & ~sts_clr[0]);
            parity_err <= parity_pulse | (parity_err & ~sts_clr[1]);
            frame_err  <= frame_pulse | (frame_err & ~sts_clr[2]);
            if (wr && req_adr == ADR_CTRL) irq_en <= req_wdat[CTRL_IRQ_EN];
            irq_o <= irq_en & (~empty | overrun | parity_err | frame_err);
        end
    end

    always_comb begin
        status                    = '0;
        status[ST_EMPTY]          = empty;
        status[ST_FULL]           = full;
        status[ST_OVERRUN]        = overrun;
        status[ST_PARITY_ERR]     = parity_err;
        status[ST_FRAME_ERR]      = frame_err;
        status[ST_COUNT_LSB +: CW] = count;
    end

    always_comb begin
        rdata = '0;
        case (req_adr)
            ADR_DATA:   rdata = empty ? 32'h0 : {23'b0, 1'b1, mem[rd_ptr]};
            ADR_STATUS: rdata = status;
            ADR_CTRL:   rdata = {31'b0, irq_en};
            ADR_RSVD:   rdata = '0;
            default:    rdata = '0;
        endcase
    end

    assign wb_dat_o = rd ? rdata : 32'h0;

endmodule

// File: tb/tb_ps2_keyboard_fifo_wb.sv
// Directed bench for the PS/2 keyboard FIFO: bit-banged frames, scoreboard of expected DATA reads.
module tb_ps2_keyboard_fifo_wb;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int TMO   = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  adr = 2'd0;
    logic [31:0] wdat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic        ack;
    logic [31:0] rdat;
    logic        ps2c = 1'b1, ps2d = 1'b1;
    logic        irq;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q [$];
    logic [31:0] r;
    logic [10:0] f;

    ps2_keyboard_fifo_wb #(
        .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(wdat), .wb_sel_i(sel), .wb_ack_o(ack), .wb_dat_o(rdat),
        .ps2clk_i(ps2c), .ps2data_i(ps2d), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rv);
        bit got = 0;
        rv = 'x;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'h1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1;
                rv  = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) chk("wb_ack_timeout", {31'b0, ack}, 32'h1);
    endtask

    task automatic wb_rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        logic [31:0] rv;
        wb_xfer(a, 1'b0, 32'h0, rv);
        chk(tag, rv, exp);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rv;
        wb_xfer(a, 1'b1, d, rv);
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        wb_rd(2'd0, tag, e);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] fr, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2d = fr[i];
            tick(10);
            ps2c = 1'b0;
            if (glitch) begin
                tick(10); ps2c = 1'b1; tick(2); ps2c = 1'b0; tick(13);
            end else begin
                tick(25);
            end
            ps2c = 1'b1;
            if (glitch) begin
                tick(5); ps2c = 1'b0; tick(2); ps2c = 1'b1; tick(8);
            end else begin
                tick(15);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
        if (!bad_par && exp_q.size() < DEPTH) exp_q.push_back({23'b0, 1'b1, b});
        ps2_bits(mk_frame(b, bad_par), 11, glitch);
        ps2d = 1'b1;
        tick(20);
    endtask

    initial begin
        tick(3);
        chk("reset_ack", {31'b0, ack}, 32'h0);
        chk("reset_dat", rdat, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        tick(2);
        wb_rd(2'd1, "reset_status", 32'h1);
        tick(1);
        chk("ack_one_cycle", {31'b0, ack}, 32'h0);

        // reset in the middle of a frame leaves no trace
        ps2_bits(mk_frame(8'h33, 0), 5, 0);
        rst = 1'b1; tick(2); rst = 1'b0; ps2d = 1'b1;
        tick(TMO + 50);
        wb_rd(2'd1, "rst_midframe_status", 32'h1);

        // first byte: sample count right after the stop-bit fall
        f = mk_frame(8'h1C, 0);
        exp_q.push_back(32'h11C);
        ps2_bits(f, 10, 0);
        ps2d = 1'b1; tick(10); ps2c = 1'b0;
        tick(SYNC + FILT);
        wb_rd(2'd1, "visibility_count", 32'h100);
        tick(15); ps2c = 1'b1; tick(30);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);
        wb_rd(2'd1, "three_bytes_status", 32'h300);
        rd_data("data_1c");
        rd_data("data_f0");
        rd_data("data_1c_2");
        rd_data("data_empty");
        wb_rd(2'd1, "drained_status", 32'h1);

        // parity error and W1C clear
        send_byte(8'h5A, 1, 0);
        wb_rd(2'd1, "parity_err_status", 32'h9);
        wb_wr(2'd1, 32'h8);
        wb_rd(2'd1, "parity_clr_status", 32'h1);

        // timeout on a truncated frame, then a clean frame
        ps2_bits(mk_frame(8'h29, 0), 5, 0);
        ps2d = 1'b1;
        tick(TMO + 100);
        wb_rd(2'd1, "timeout_status", 32'h11);
        wb_wr(2'd1, 32'h10);
        send_byte(8'h29, 0, 0);
        rd_data("data_29");
        wb_rd(2'd1, "post_timeout_status", 32'h1);

        // overrun
        for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h10 + 8'(i), 0, 0);
        wb_rd(2'd1, "overrun_status", (32'(DEPTH) << 8) | 32'h6);
        for (int i = 0; i < DEPTH; i++) rd_data($sformatf("overrun_data_%0d", i));
        rd_data("overrun_lost");
        wb_wr(2'd1, 32'h4);
        wb_rd(2'd1, "overrun_clr_status", 32'h1);

        // flush
        send_byte(8'h44, 0, 0);
        send_byte(8'h55, 0, 0);
        wb_rd(2'd1, "preflush_status", 32'h200);
        wb_wr(2'd2, 32'h2);
        exp_q.delete();
        wb_rd(2'd1, "flush_status", 32'h1);
        wb_rd(2'd2, "flush_selfclear", 32'h0);
        rd_data("flush_data_empty");

        // interrupt
        wb_wr(2'd2, 32'h1);
        wb_rd(2'd2, "ctrl_irq_en", 32'h1);
        chk("irq_idle", {31'b0, irq}, 32'h0);
        send_byte(8'h76, 0, 0);
        chk("irq_on_byte", {31'b0, irq}, 32'h1);
        rd_data("data_76");
        tick(1);
        chk("irq_lag", {31'b0, irq}, 32'h1);
        tick(1);
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        wb_wr(2'd2, 32'h0);

        // clock glitches shorter than the filter
        send_byte(8'hA5, 0, 1);
        wb_rd(2'd1, "glitch_status", 32'h100);
        rd_data("glitch_data");
        wb_rd(2'd3, "reserved_read", 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
